// File: rtl/lc3b_mem_responder_if.sv
// Word-wide request/response bus between the LC-3b CPU (master) and its main memory (slave).
// Requests are held by the master until the single-cycle mem_resp pulse.
interface lc3b_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        mem_err;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_rdata,
        input  mem_resp,
        input  mem_err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata,
        output mem_resp,
        output mem_err
    );
endinterface

// File: rtl/lc3b_mem_responder.sv
// LC-3b main memory: byte-laned word array that answers each held request with a
// one-cycle mem_resp LATENCY cycles after the request first appears.
module lc3b_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lc3b_mem_responder_if.slave  bus
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic                    err_reg, err_next;

    logic [DEPTH_LOG2-1:0]   req_idx_reg;
    logic [15:0]             req_wdata_reg;
    logic [1:0]              req_be_reg;
    logic                    req_write_reg;

    logic                    req_any;
    logic                    accept;
    logic                    commit;
    logic                    commit_from_inputs;
    logic                    commit_en;
    logic                    resp;
    logic [DEPTH_LOG2-1:0]   commit_idx;
    logic [15:0]             commit_wdata;
    logic [1:0]              commit_be;
    logic                    commit_write;
    logic                    unused_addr_bits;

    assign req_any = bus.mem_read | bus.mem_write;
    assign accept  = (state_reg == ST_IDLE) && req_any;

    // Address bit 0 and everything above the array index alias onto the same word.
    assign unused_addr_bits = ^{bus.mem_address[15:DEPTH_LOG2+1], bus.mem_address[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        err_next           = err_reg;
        commit             = 1'b0;
        commit_from_inputs = 1'b0;
        resp               = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_any) begin
                    cnt_next = LAT_M1;
                    if (bus.mem_read && bus.mem_write) begin
                        err_next = 1'b1;
                    end
                    // A single-cycle latency commits straight from the live bus.
                    if (LATENCY == 1) begin
                        state_next         = ST_RESP;
                        commit             = 1'b1;
                        commit_from_inputs = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_any) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                    err_next   = 1'b1;
                end else if (cnt_reg == 4'd1) begin
                    state_next = ST_RESP;
                    cnt_next   = 4'd0;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                resp       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request fields are frozen at acceptance; the bus may change freely afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_idx_reg   <= bus.mem_address[DEPTH_LOG2:1];
            req_wdata_reg <= bus.mem_wdata;
            req_be_reg    <= bus.mem_byte_enable;
            req_write_reg <= bus.mem_write;
        end
    end

    assign commit_idx   = commit_from_inputs ? bus.mem_address[DEPTH_LOG2:1] : req_idx_reg;
    assign commit_wdata = commit_from_inputs ? bus.mem_wdata                 : req_wdata_reg;
    assign commit_be    = commit_from_inputs ? bus.mem_byte_enable           : req_be_reg;
    assign commit_write = commit_from_inputs ? bus.mem_write                 : req_write_reg;
    assign commit_en    = commit && rst_n;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rdata_lane_reg;

            always_ff @(posedge clk) begin
                if (commit_en && commit_write && commit_be[gi]) begin
                    lane_mem[commit_idx] <= commit_wdata[8*gi +: 8];
                end
            end

            // Read data is only reloaded by read completions, so writes leave it intact.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_lane_reg <= 8'h00;
                end else if (commit_en && !commit_write) begin
                    rdata_lane_reg <= lane_mem[commit_idx];
                end
            end
        end
    endgenerate

    assign bus.mem_rdata = {g_lane[1].rdata_lane_reg, g_lane[0].rdata_lane_reg};
    assign bus.mem_resp  = resp;
    assign bus.mem_err   = err_reg;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench for lc3b_mem_responder: a LATENCY=3 instance and a LATENCY=1 instance
// share one stimulus driver; sel picks which one receives the requests.
module tb_lc3b_mem_responder;

    localparam int BUDGET = 40;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        rd, wr;
    logic [1:0]  be;
    logic [15:0] addr, wdata;
    int          cur_lat;
    int          n_checks;
    int          n_errors;

    lc3b_mem_responder_if if_a ();
    lc3b_mem_responder_if if_b ();

    lc3b_mem_responder #(.DEPTH_LOG2(8), .LATENCY(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    lc3b_mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    assign if_a.mem_read        = rd & ~sel;
    assign if_a.mem_write       = wr & ~sel;
    assign if_a.mem_byte_enable = be;
    assign if_a.mem_address     = addr;
    assign if_a.mem_wdata       = wdata;
    assign if_b.mem_read        = rd & sel;
    assign if_b.mem_write       = wr & sel;
    assign if_b.mem_byte_enable = be;
    assign if_b.mem_address     = addr;
    assign if_b.mem_wdata       = wdata;

    logic        resp_sel, err_sel;
    logic [15:0] rdata_sel;
    assign resp_sel  = sel ? if_b.mem_resp  : if_a.mem_resp;
    assign err_sel   = sel ? if_b.mem_err   : if_a.mem_err;
    assign rdata_sel = sel ? if_b.mem_rdata : if_a.mem_rdata;

    typedef struct {
        bit          is_read;
        logic [15:0] exp;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the responder idle; returns at a negedge one cycle after resp.
    task automatic txn(input string tag, input logic r, input logic w, input logic [1:0] b,
                       input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
        sb_t e;
        int  n;
        bit  got;
        e.is_read = r & ~w;
        e.exp     = exp_rd;
        e.tag     = tag;
        sb_q.push_back(e);
        rd = r; wr = w; be = b; addr = a; wdata = d;
        n   = 0;
        got = 0;
        while (!got && n < BUDGET) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (resp_sel) got = 1;
        end
        chk({tag, "_lat"}, n, cur_lat);
        e = sb_q.pop_front();
        if (got && e.is_read) chk({tag, "_rdata"}, rdata_sel, e.exp);
        $display("txn %s rd=%0b wr=%0b be=%b addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
                 tag, r, w, b, a, d, n, rdata_sel, err_sel);
        rd = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        chk({tag, "_single"}, resp_sel, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        sel = 1'b0; cur_lat = 3;
        rd = 1'b0; wr = 1'b0; be = 2'b00; addr = 16'h0; wdata = 16'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp",  if_a.mem_resp,  1'b0);
        chk("rst_rdata", if_a.mem_rdata, 16'h0000);
        chk("rst_err",   if_a.mem_err,   1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        txn("w_beef", 1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 16'h0);
        txn("r_beef", 1'b1, 1'b0, 2'b11, 16'h0010, 16'h0000, 16'hBEEF);

        txn("w_lane11", 1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, 16'h0);
        txn("w_lane10", 1'b0, 1'b1, 2'b10, 16'h0021, 16'hAB00, 16'h0);
        txn("w_lane01", 1'b0, 1'b1, 2'b01, 16'h0020, 16'h00CD, 16'h0);
        txn("r_lanes",  1'b1, 1'b0, 2'b11, 16'h0020, 16'h0000, 16'hABCD);

        txn("w_alias",  1'b0, 1'b1, 2'b11, 16'h0202, 16'h5555, 16'h0);
        txn("r_alias",  1'b1, 1'b0, 2'b11, 16'h0002, 16'h0000, 16'h5555);
        txn("w_be00",   1'b0, 1'b1, 2'b00, 16'h0002, 16'hFFFF, 16'h0);
        txn("r_be00",   1'b1, 1'b0, 2'b11, 16'h0002, 16'h0000, 16'h5555);
        chk("err_clean", err_sel, 1'b0);

        txn("w_both", 1'b1, 1'b1, 2'b11, 16'h0030, 16'h0F0F, 16'h0);
        chk("err_both", err_sel, 1'b1);
        txn("r_both", 1'b1, 1'b0, 2'b11, 16'h0030, 16'h0000, 16'h0F0F);

        // Drop a write after one WAIT cycle.
        rd = 1'b0; wr = 1'b1; be = 2'b11; addr = 16'h0030; wdata = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        chk("abort_wait", resp_sel, 1'b0);
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_noresp", resp_sel, 1'b0);
        end
        $display("txn abort addr=0030 wdata=9999 err=%0b", err_sel);
        chk("err_abort", err_sel, 1'b1);
        txn("r_abort", 1'b1, 1'b0, 2'b11, 16'h0030, 16'h0000, 16'h0F0F);
        chk("err_sticky", err_sel, 1'b1);

        txn("w_1111", 1'b0, 1'b1, 2'b11, 16'h0040, 16'h1111, 16'h0);
        txn("r_1111", 1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h1111);

        // Reset lands while the 7777 write is waiting.
        wr = 1'b1; be = 2'b11; addr = 16'h0040; wdata = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_resp",  if_a.mem_resp,  1'b0);
        chk("midrst_rdata", if_a.mem_rdata, 16'h0000);
        chk("midrst_err",   if_a.mem_err,   1'b0);
        $display("txn reset_mid_write addr=0040 wdata=7777 rdata=%h err=%0b", if_a.mem_rdata, if_a.mem_err);
        wr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn("r_after_rst", 1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h1111);

        sel = 1'b1;
        cur_lat = 1;
        @(negedge clk);
        txn("l1_w_init",  1'b0, 1'b1, 2'b11, 16'h0060, 16'h1234, 16'h0);
        txn("l1_r_fetch", 1'b1, 1'b0, 2'b11, 16'h0060, 16'h0000, 16'h1234);
        txn("l1_w_str",   1'b0, 1'b1, 2'b11, 16'h0060, 16'h4321, 16'h0);
        txn("l1_r_back",  1'b1, 1'b0, 2'b11, 16'h0060, 16'h0000, 16'h4321);
        chk("l1_err", err_sel, 1'b0);
        chk("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
